vproc_mem_responder: RTL and testbench
======================================

# vproc_mem_responder

Memory-side responder for the vector processor's request/grant/rvalid memory interface. It accepts word-aligned read and write requests, such as line fills and spills from the vector cache, and backs them with a synchronous byte array. Read data returns after a fixed, parameterised latency, and an optional pseudo-random grant-stall generator stresses the initiator. It serves as the simulation/FPGA memory behind the cache and as the verification counterpart of any initiator on this interface.

## Interface
- ADDR_BIT_W, 16, address width (bits)
- MEM_BYTE_W, 4, data width (bytes), power of two
- MEM_SIZE, 65536, backing store size (bytes), multiple of MEM_BYTE_W
- LATENCY, 2, cycles from grant cycle to rvalid cycle, ≥1
- ERR_BASE, 16'hF000, first byte address of error window
- ERR_SIZE, 16'h0100, error window size (bytes), 0 disables window
- STALL_SEED, 16'hACE1, LFSR seed (stall feature only), nonzero
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  asynchronous, active-high reset
- mem_req_i  in  1  request valid
- mem_addr_i  in  ADDR_BIT_W  byte address; low log2(MEM_BYTE_W) bits ignored
- mem_we_i  in  1  1 = write, 0 = read
- mem_wdata_i  in  MEM_BYTE_W*8  write data, full word
- mem_gnt_o  out  1  request accepted this cycle
- mem_rvalid_o  out  1  read response valid
- mem_rdata_o  out  MEM_BYTE_W*8  read data
- mem_err_o  out  1  read response error, valid with mem_rvalid_o

## Operation
- A request is accepted in every cycle where mem_req_i & mem_gnt_o. The initiator holds its address, we and wdata stable until the grant.
- mem_gnt_o is combinational: mem_req_i & ~rst_i & ~stall. Without the stall feature, stall = 0.
- Accepted write: stores the full word at the rising edge ending the grant cycle. Produces no rvalid. The initiator counts only read responses, so a late write response would corrupt fill counting.
- Accepted read: the word is read at the grant edge and enters a LATENCY-stage response pipeline as {valid, err, data}. It emerges as mem_rvalid_o exactly LATENCY cycles after the grant cycle.
- Error address: word address ≥ MEM_SIZE, or inside [ERR_BASE, ERR_BASE+ERR_SIZE).
  - Read to an error address: err=1, rdata=0.
  - Write to an error address: dropped. The grant is still given and no error is signalled.
- Reads return in grant order. At most one request is accepted per cycle, so the pipeline never overflows and has no backpressure.
- Read-after-write: a read granted in any cycle after a write's grant cycle returns the new data.
- Memory content: zero-initialised at time 0 and not touched by reset.

## Timing
- Reset values: mem_gnt_o=0, mem_rvalid_o=0, mem_rdata_o=0, mem_err_o=0. The pipeline is cleared and the LFSR is loaded with STALL_SEED.
- Reset mid-operation: in-flight reads are dropped with no rvalid after reset. Writes granted before reset assertion remain committed.
- Latency: grant in cycle N gives rvalid in cycle N+LATENCY. Back-to-back grants give back-to-back rvalids.
- With no response in a stage, mem_rdata_o and mem_err_o are 0 whenever mem_rvalid_o=0.
- The first grant is possible in the first cycle after rst_i deasserts.

## Configuration
- Macro: VPROC_MEM_RESP_STALL_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11) advances every cycle.
  - stall = (lfsr[1:0] == 2'b00), giving about 25% grant suppression that is independent of mem_req_i.
  - The stall sequence is deterministic from STALL_SEED.
- Undefined: no LFSR logic, and mem_gnt_o = mem_req_i & ~rst_i.

## Structure
- Package vproc_mem_pkg holds:
  - typedef mem_resp_t (valid, err, data, parameterised via the module's width)
  - the LFSR tap constant
  - the default stall seed
- Sub-module vproc_mem_resp_pipe implements the fixed-latency shift register of mem_resp_t with asynchronous clear. The top level keeps the array, the address decode and the stall generator.

## Test plan
- Write 32'hDEADBEEF to 16'h0010 (grant cycle N), then read 16'h0010 at N+1: rvalid=1 at cycle N+1+LATENCY, rdata=32'hDEADBEEF, err=0, and no rvalid for the write.
- Read 16'hF004: err=1 and rdata=0 after LATENCY. A prior write of 32'h12345678 to 16'hF004 is dropped, and reading 16'h0004 afterwards returns 0.
- Four back-to-back reads of 16'h0000/4/8/C after writing 1/2/3/4: rvalid high for four consecutive cycles, with rdata 1,2,3,4 in order.
- Assert rst_i while two reads are in flight: no rvalid in the following cycles. A re-read of the addresses returns the pre-reset written data.
- With VPROC_MEM_RESP_STALL_EN and seed 16'hACE1, hold req for 64 cycles: gnt pattern matches the reference LFSR model exactly, and roughly 16 cycles are stalled.
- Drive the cache fill-after-spill pattern (4 writes then 4 reads, LATENCY=3): exactly 4 rvalids, all with err=0.

Source files
------------

// File: rtl/vproc_mem_pkg.sv
// vproc_mem_pkg: response bundle and stall-generator constants shared by
// the memory responder and its response pipeline.
package vproc_mem_pkg;

    localparam int unsigned RESP_DATA_W_MAX = 512;

    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    localparam logic [15:0] STALL_SEED_DEFAULT = 16'hACE1;

    typedef struct packed {
        logic                       valid;
        logic                       err;
        logic [RESP_DATA_W_MAX-1:0] data;
    } mem_resp_t;

endpackage

// File: rtl/vproc_mem_resp_pipe.sv
// vproc_mem_resp_pipe: fixed-latency shift register of read responses.
// Reset drops every response still in flight.
module vproc_mem_resp_pipe
    import vproc_mem_pkg::*;
#(
    parameter int unsigned LATENCY = 2
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  mem_resp_t resp_i,
    output mem_resp_t resp_o
);

    mem_resp_t stage_q [LATENCY];

    // advance every response one stage per cycle
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(LATENCY); i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= resp_i;
            for (int i = 1; i < int'(LATENCY); i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign resp_o = stage_q[LATENCY-1];

endmodule

// File: rtl/vproc_mem_responder.sv
// vproc_mem_responder: word-wide memory behind a req/gnt/rvalid port.
// Define VPROC_MEM_RESP_STALL_EN to enable LFSR-driven grant stalls.
module vproc_mem_responder
    import vproc_mem_pkg::*;
#(
    parameter int unsigned ADDR_BIT_W = 16,
    parameter int unsigned MEM_BYTE_W = 4,
    parameter int unsigned MEM_SIZE   = 65536,
    parameter int unsigned LATENCY    = 2,
    parameter int unsigned ERR_BASE   = 32'h0000_F000,
    parameter int unsigned ERR_SIZE   = 32'h0000_0100,
    parameter int unsigned STALL_SEED = 32'(STALL_SEED_DEFAULT)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    mem_req_i,
    input  logic [ADDR_BIT_W-1:0]   mem_addr_i,
    input  logic                    mem_we_i,
    input  logic [MEM_BYTE_W*8-1:0] mem_wdata_i,
    output logic                    mem_gnt_o,
    output logic                    mem_rvalid_o,
    output logic [MEM_BYTE_W*8-1:0] mem_rdata_o,
    output logic                    mem_err_o
);

    localparam int unsigned DATA_W    = MEM_BYTE_W * 8;
    localparam int unsigned MEM_WORDS = MEM_SIZE / MEM_BYTE_W;
    localparam int unsigned OFF_W     = $clog2(MEM_BYTE_W);
    localparam int unsigned IDX_W     = $clog2(MEM_WORDS);

    logic [DATA_W-1:0] mem_q [MEM_WORDS] = '{default: '0};

    logic [31:0]      waddr;
    logic [IDX_W-1:0] word_idx;
    logic             addr_err;
    logic             stall;
    mem_resp_t        pipe_in;
    mem_resp_t        pipe_out;

    assign waddr    = 32'(mem_addr_i) & ~32'(MEM_BYTE_W - 1);
    assign word_idx = waddr[OFF_W +: IDX_W];

    assign addr_err = (waddr >= MEM_SIZE)
                   || ((ERR_SIZE != 0)
                       && (waddr >= ERR_BASE)
                       && (waddr < ERR_BASE + ERR_SIZE));

`ifdef VPROC_MEM_RESP_STALL_EN
    logic [15:0] lfsr_q;

    // free-running Fibonacci LFSR, shifted right with feedback at the top
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lfsr_q <= STALL_SEED[15:0];
        end else begin
            lfsr_q <= {^(lfsr_q & LFSR_TAPS), lfsr_q[15:1]};
        end
    end

    assign stall = (lfsr_q[1:0] == 2'b00);
`else
    logic unused_seed;
    assign unused_seed = ^STALL_SEED[15:0];
    assign stall       = 1'b0;
`endif

    assign mem_gnt_o = mem_req_i & ~rst_i & ~stall;

    // commit granted writes; writes into the error range are dropped
    always_ff @(posedge clk_i) begin
        if (mem_gnt_o && mem_we_i && !addr_err) begin
            mem_q[word_idx] <= mem_wdata_i;
        end
    end

    // build the response entering the pipeline in the grant cycle
    always_comb begin
        pipe_in       = '0;
        pipe_in.valid = mem_gnt_o & ~mem_we_i;
        pipe_in.err   = mem_gnt_o & ~mem_we_i & addr_err;
        if (mem_gnt_o && !mem_we_i && !addr_err) begin
            pipe_in.data[DATA_W-1:0] = mem_q[word_idx];
        end
    end

    vproc_mem_resp_pipe #(
        .LATENCY (LATENCY)
    ) u_pipe (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .resp_i (pipe_in),
        .resp_o (pipe_out)
    );

    assign mem_rvalid_o = pipe_out.valid;
    assign mem_err_o    = pipe_out.err;
    assign mem_rdata_o  = pipe_out.data[DATA_W-1:0];

    if (DATA_W < RESP_DATA_W_MAX) begin : g_hi
        logic unused_resp_hi;
        assign unused_resp_hi = ^pipe_out.data[RESP_DATA_W_MAX-1:DATA_W];
    end

endmodule

// File: tb/tb_vproc_mem_responder.sv
// tb_vproc_mem_responder: table-driven and random checks of the responder
// against a queue/array reference model of the memory port.
module tb_vproc_mem_responder;

    localparam int LAT = 3;
    localparam int unsigned SEED = 32'h0000_ACE1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic [15:0] addr = '0;
    logic        we = 1'b0;
    logic [31:0] wdata = '0;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    logic        tbl_v = 1'b0;
    logic        tbl_e = 1'b0;
    logic [31:0] tbl_d = '0;

    int nchk = 0;
    int nerr = 0;
    int cyc = 0;
    int rv_cnt = 0;
    bit last_gnt = 1'b0;
    int lfsr_m = int'(SEED);

    typedef struct {
        int          due;
        bit          err;
        logic [31:0] data;
        bit          tv;
        bit          te;
        logic [31:0] td;
    } exp_t;

    typedef struct {
        bit          we;
        logic [15:0] addr;
        logic [31:0] wdata;
        bit          err;
        logic [31:0] rdata;
    } vec_t;

    exp_t        sq[$];
    logic [31:0] mdl [int];
    vec_t        tbl [21];

    vproc_mem_responder #(
        .LATENCY (LAT)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .mem_req_i    (req),
        .mem_addr_i   (addr),
        .mem_we_i     (we),
        .mem_wdata_i  (wdata),
        .mem_gnt_o    (gnt),
        .mem_rvalid_o (rvalid),
        .mem_rdata_o  (rdata),
        .mem_err_o    (err)
    );

    always #5 clk = ~clk;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    function automatic bit is_err_addr(int unsigned a);
        int unsigned w = a & ~32'd3;
        return (w >= 65536) || (w >= 32'hF000 && w < 32'hF100);
    endfunction

    function automatic bit stall_now();
`ifdef VPROC_MEM_RESP_STALL_EN
        return (lfsr_m % 4) == 0;
`else
        return 1'b0;
`endif
    endfunction

    // reference LFSR: x^16+x^14+x^13+x^11+1, right-shifting form
    always @(posedge clk) begin
        int b;
        cyc++;
        if (rst) begin
            lfsr_m = int'(SEED);
        end else begin
            b = (lfsr_m ^ (lfsr_m >> 2) ^ (lfsr_m >> 3) ^ (lfsr_m >> 5)) & 1;
            lfsr_m = (lfsr_m >> 1) | (b << 15);
        end
    end

    // mid-cycle monitor: grant, response stream and memory model
    always @(negedge clk) begin
        bit eg;
        int w;
        exp_t e;
        if (rst) sq.delete();
        eg = req & ~rst & ~stall_now();
        chk("gnt", gnt, eg);
        if (rvalid === 1'b1) rv_cnt++;
        if (sq.size() > 0 && sq[0].due == cyc) begin
            e = sq.pop_front();
            chk("rvalid", rvalid, 1);
            chk("rerr", err, e.err);
            chk("rdata", rdata, e.data);
            if (e.tv) begin
                chk("tbl_err", err, e.te);
                chk("tbl_data", rdata, e.td);
            end
        end else begin
            chk("idle_out", {rvalid, err, rdata}, 34'd0);
        end
        if (eg) begin
            w = int'(addr) & ~3;
            if (we) begin
                if (!is_err_addr(addr)) mdl[w] = wdata;
            end else begin
                e.due  = cyc + LAT;
                e.err  = is_err_addr(addr);
                e.data = (e.err || !mdl.exists(w)) ? 32'd0 : mdl[w];
                e.tv   = tbl_v;
                e.te   = tbl_e;
                e.td   = tbl_d;
                sq.push_back(e);
            end
        end
        last_gnt = eg;
    end

    task automatic op(bit w, logic [15:0] a, logic [31:0] d,
                      bit tv, bit te, logic [31:0] td);
        int n;
        @(posedge clk);
        #1;
        req = 1'b1; we = w; addr = a; wdata = d;
        tbl_v = tv; tbl_e = te; tbl_d = td;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!last_gnt && n < 100);
        if (!last_gnt) begin
            nchk++;
            nerr++;
            $display("FAIL gnt_wait: no grant after %0d cycles", n);
        end
    endtask

    task automatic idle(int n);
        @(posedge clk);
        #1;
        req = 1'b0;
        tbl_v = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int rv0;
        int g;
        logic [31:0] d [4];
        logic [15:0] a;

        tbl[0]  = '{1'b1, 16'h0010, 32'hDEADBEEF, 1'b0, 32'h0};
        tbl[1]  = '{1'b0, 16'h0010, 32'h0, 1'b0, 32'hDEADBEEF};
        tbl[2]  = '{1'b0, 16'h0013, 32'h0, 1'b0, 32'hDEADBEEF};
        tbl[3]  = '{1'b1, 16'hF004, 32'h12345678, 1'b0, 32'h0};
        tbl[4]  = '{1'b0, 16'hF004, 32'h0, 1'b1, 32'h0};
        tbl[5]  = '{1'b0, 16'h0004, 32'h0, 1'b0, 32'h0};
        tbl[6]  = '{1'b1, 16'h0000, 32'h1, 1'b0, 32'h0};
        tbl[7]  = '{1'b1, 16'h0004, 32'h2, 1'b0, 32'h0};
        tbl[8]  = '{1'b1, 16'h0008, 32'h3, 1'b0, 32'h0};
        tbl[9]  = '{1'b1, 16'h000C, 32'h4, 1'b0, 32'h0};
        tbl[10] = '{1'b0, 16'h0000, 32'h0, 1'b0, 32'h1};
        tbl[11] = '{1'b0, 16'h0004, 32'h0, 1'b0, 32'h2};
        tbl[12] = '{1'b0, 16'h0008, 32'h0, 1'b0, 32'h3};
        tbl[13] = '{1'b0, 16'h000C, 32'h0, 1'b0, 32'h4};
        tbl[14] = '{1'b1, 16'hF0FC, 32'hA5A5A5A5, 1'b0, 32'h0};
        tbl[15] = '{1'b0, 16'hF0FC, 32'h0, 1'b1, 32'h0};
        tbl[16] = '{1'b1, 16'hF100, 32'h00C0FFEE, 1'b0, 32'h0};
        tbl[17] = '{1'b0, 16'hF100, 32'h0, 1'b0, 32'h00C0FFEE};
        tbl[18] = '{1'b0, 16'hEFFC, 32'h0, 1'b0, 32'h0};
        tbl[19] = '{1'b1, 16'hEFFC, 32'h77, 1'b0, 32'h0};
        tbl[20] = '{1'b0, 16'hEFFC, 32'h0, 1'b0, 32'h77};

        req = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 21; i++) begin
            op(tbl[i].we, tbl[i].addr, tbl[i].wdata,
               !tbl[i].we, tbl[i].err, tbl[i].rdata);
        end
        idle(LAT + 2);

        op(1'b0, 16'h0000, 32'h0, 1'b1, 1'b0, 32'h1);
        op(1'b0, 16'h0004, 32'h0, 1'b1, 1'b0, 32'h2);
        @(posedge clk);
        #1;
        rst = 1'b1; req = 1'b1; we = 1'b0; addr = '0; tbl_v = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        rv0 = rv_cnt;
        idle(LAT + 2);
        chk("rst_no_rvalid", rv_cnt - rv0, 0);
        op(1'b0, 16'h0000, 32'h0, 1'b1, 1'b0, 32'h1);
        op(1'b0, 16'h0004, 32'h0, 1'b1, 1'b0, 32'h2);
        idle(LAT + 2);

        @(posedge clk);
        #1;
        req = 1'b1; we = 1'b0; addr = 16'h0008; tbl_v = 1'b0;
        g = 0;
        repeat (64) begin
            @(negedge clk);
            #1;
            if (gnt === 1'b1) g++;
        end
`ifdef VPROC_MEM_RESP_STALL_EN
        chk("stall_range", (64 - g >= 8) && (64 - g <= 24), 1);
`else
        chk("stall_cnt", 64 - g, 0);
`endif
        idle(LAT + 2);

        rv0 = rv_cnt;
        for (int i = 0; i < 4; i++) begin
            d[i] = $urandom;
            op(1'b1, 16'(16'h0100 + 4 * i), d[i], 1'b0, 1'b0, 32'h0);
        end
        for (int i = 0; i < 4; i++) begin
            op(1'b0, 16'(16'h0100 + 4 * i), 32'h0, 1'b1, 1'b0, d[i]);
        end
        idle(LAT + 2);
        chk("fill_rvalids", rv_cnt - rv0, 4);

        for (int k = 0; k < 300; k++) begin
            case ($urandom_range(0, 3))
                0: a = 16'($urandom_range(0, 16'h003F));
                1: a = 16'($urandom_range(16'hF0F0, 16'hF10F));
                2: a = 16'($urandom);
                default: a = 16'($urandom_range(16'h0100, 16'h010F));
            endcase
            op(1'($urandom_range(0, 1)), a, $urandom, 1'b0, 1'b0, 32'h0);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(0, LAT));
        end
        idle(LAT + 2);
        chk("drain", sq.size(), 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
